div_sequencer: RTL and testbench
================================

// Module: div_sequencer
// PURPOSE
//   Multi-cycle radix-2 restoring divider sequencer for the EX stage. Serves DIV/DIVU.
//   Raises stall_div to hold the pipeline while the divide runs.
//   Delivers {HI=remainder, LO=quotient} as a 64-bit result for the hilo write path.
//   Sits beside the ALU and drives the hazard unit's stall_divE input.
// PARAMETERS
//   WIDTH   32  operand width; quotient and remainder are each WIDTH bits
//   CNT_W   6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   clk           in   1        clock, rising edge
//   rst           in   1        asynchronous, active-low reset
//   start_i       in   1        DIV/DIVU present in EX; level, held while stalled
//   signed_i      in   1        1 = DIV (signed), 0 = DIVU
//   flush_i       in   1        cancel in-flight divide (EX flush/exception)
//   opa_i         in   WIDTH    dividend (rs), sampled on accept
//   opb_i         in   WIDTH    divisor (rt), sampled on accept
//   stall_div_o   out  1        pipeline stall request
//   busy_o        out  1        state != IDLE
//   valid_o       out  1        result valid, 1-cycle pulse
//   divzero_o     out  1        with valid_o: divisor was zero
//   result_o      out  2*WIDTH  {remainder, quotient}
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, cnt=0. All outputs 0, including result_o.
//   FSM states: IDLE, CALC, DONE.
//   IDLE:
//     start_i & ~flush_i -> accept. Latch |opa|, |opb|, sign flags, and opb==0.
//     Divisor zero -> DONE. Otherwise -> CALC with cnt=0.
//   CALC:
//     One restoring step per cycle: shift {rem,quo} left 1, trial-subtract divisor.
//     Keep the difference and set quo[0]=1 when the subtraction is non-negative.
//     cnt increments each cycle; CALC lasts exactly WIDTH cycles (cnt==WIDTH-1 -> DONE).
//   DONE:
//     valid_o=1. result_o holds the sign-fixed result. Next state IDLE unconditionally.
//     start_i in DONE is ignored: it is the same, now-retiring instruction.
//   stall_div_o = ~flush_i & ((IDLE & start_i) | CALC). Combinational, asserts in the accept cycle.
//   Latency: accept at cycle T; CALC T+1..T+WIDTH; DONE/valid at T+WIDTH+1.
//     Stall is high for WIDTH+1 cycles (T..T+WIDTH) and low in DONE.
//   Sign fix (signed_i=1):
//     Quotient negated iff operand signs differ; remainder takes the dividend's sign.
//     Negation is 2's complement truncated to WIDTH bits.
//     0x80000000 / -1 -> quotient 0x80000000, remainder 0, no flag.
//   Divide by zero: DONE at T+1, result_o=0, divzero_o=1. No stall beyond cycle T.
//   flush_i: highest priority, in any state. Next state IDLE; valid_o not asserted.
//     stall_div_o forced 0 in the flush cycle.
//   result_o is updated only on entry to DONE and held until the next DONE or reset.
//   Back-to-back divides: a second accept is possible in the IDLE cycle right after DONE.
// CONFIGURATION
//   DIV_EARLY_EXIT_EN defined:
//     In IDLE, nonzero divisor with |opa| < |opb| -> DONE directly.
//     Quotient 0, remainder = opa_i (original sign). Latency T+1.
//   DIV_EARLY_EXIT_EN undefined:
//     Every nonzero-divisor operation runs the full WIDTH CALC cycles.
// TESTING
//   1. DIVU 100/7, start at T -> stall T..T+32; valid at T+33; result_o={32'd2,32'd14}.
//   2. DIV -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; DIV 7/-2 -> 0xFFFFFFFD, 0x00000001.
//   3. DIV 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0, divzero_o=0.
//   4. DIVU 5/0 -> valid and divzero_o at T+1, result_o=0, stall only at T.
//   5. flush_i at T+10 of DIVU 100/7 -> IDLE at T+11, no valid, stall 0 at T+10.
//        New start at T+12 completes correctly at T+45.
//      Also: rst low at T+5 -> outputs 0 immediately; recovers after release.
//   6. DIVU 3/5: with DIV_EARLY_EXIT_EN -> valid at T+1, {3,0}; without -> valid at T+33, {3,0}.

Source files
------------

// File: rtl/div_sequencer_if.sv
// -----------------------------------------------------------------------------
// div_sequencer_if
//   Bundles the EX-stage divide handshake between the pipeline and the
//   multi-cycle divider.
//
//   master : pipeline side. Drives start/signed/flush/operands and observes
//            the stall, busy, valid, divide-by-zero and result signals.
//   slave  : divider side. Mirror image of master.
//
//   start_i     DIV/DIVU present in EX (level, held while stalled)
//   signed_i    1 = DIV, 0 = DIVU
//   flush_i     cancel any in-flight divide
//   opa_i       dividend (rs)
//   opb_i       divisor (rt)
//   stall_div_o pipeline stall request
//   busy_o      divider not idle
//   valid_o     one-cycle result strobe
//   divzero_o   qualifies valid_o: the divisor was zero
//   result_o    {remainder, quotient}
// -----------------------------------------------------------------------------
interface div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic                 start_i;
  logic                 signed_i;
  logic                 flush_i;
  logic [WIDTH-1:0]     opa_i;
  logic [WIDTH-1:0]     opb_i;
  logic                 stall_div_o;
  logic                 busy_o;
  logic                 valid_o;
  logic                 divzero_o;
  logic [2*WIDTH-1:0]   result_o;

  modport master (
    output start_i, signed_i, flush_i, opa_i, opb_i,
    input  stall_div_o, busy_o, valid_o, divzero_o, result_o
  );

  modport slave (
    input  start_i, signed_i, flush_i, opa_i, opb_i,
    output stall_div_o, busy_o, valid_o, divzero_o, result_o
  );
endinterface

// File: rtl/div_sequencer.sv
// -----------------------------------------------------------------------------
// div_sequencer
//   Radix-2 restoring divider for DIV/DIVU in the EX stage. Operands are
//   converted to magnitudes on accept, WIDTH restoring steps run one per
//   cycle, and the sign-corrected {remainder, quotient} is registered on entry
//   to DONE for the HI/LO write path. stall_div_o holds the pipeline from the
//   accept cycle until the last CALC cycle.
//
// Ports
//   clk   rising-edge clock
//   rst   asynchronous, active-low reset
//   bus   div_sequencer_if.slave (start/signed/flush/operands in;
//         stall/busy/valid/divzero/result out)
//
// Configuration
//   DIV_EARLY_EXIT_EN : when defined, a nonzero-divisor op with
//                       |dividend| < |divisor| finishes straight from IDLE
//                       with quotient 0 and remainder = original dividend.
//                       When undefined, every nonzero-divisor op runs the
//                       full WIDTH CALC cycles.
// -----------------------------------------------------------------------------
module div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic           clk,
  input  logic           rst,
  div_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 dz_q, dz_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  // Operand magnitudes and signs (only meaningful for signed ops)
  logic                 opa_neg, opb_neg;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic                 early_exit;

  // One restoring step on the current partial remainder/quotient
  logic [WIDTH:0]       shifted, trial;
  logic [WIDTH-1:0]     rem_step, quo_step;
  logic [WIDTH-1:0]     rem_fix, quo_fix;

  always_comb begin
    opa_neg = bus.signed_i & bus.opa_i[WIDTH-1];
    opb_neg = bus.signed_i & bus.opb_i[WIDTH-1];
    abs_a   = opa_neg ? (~bus.opa_i + 1'b1) : bus.opa_i;
    abs_b   = opb_neg ? (~bus.opb_i + 1'b1) : bus.opb_i;
  end

`ifdef DIV_EARLY_EXIT_EN
  // Quotient is known to be zero; skip the iterations.
  assign early_exit = (abs_a < abs_b);
`else
  assign early_exit = 1'b0;
`endif

  always_comb begin
    // Shift the next dividend bit into the remainder. The partial remainder
    // is always below the divisor, so a non-borrowing difference fits in
    // WIDTH bits and a borrow shows up in bit WIDTH.
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    if (!trial[WIDTH]) begin
      rem_step = trial[WIDTH-1:0];
      quo_step = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_step = shifted[WIDTH-1:0];
      quo_step = {quo_q[WIDTH-2:0], 1'b0};
    end
    // Truncated 2's complement negation; MIN / -1 wraps back to MIN.
    quo_fix = neg_quo_q ? (~quo_step + 1'b1) : quo_step;
    rem_fix = neg_rem_q ? (~rem_step + 1'b1) : rem_step;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    result_d  = result_q;

    if (bus.flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            neg_quo_d = opa_neg ^ opb_neg;
            neg_rem_d = opa_neg;
            dvs_d     = abs_b;
            rem_d     = '0;
            quo_d     = abs_a;
            cnt_d     = '0;
            if (bus.opb_i == '0) begin
              dz_d     = 1'b1;
              result_d = '0;
              state_d  = DONE;
            end else if (early_exit) begin
              dz_d     = 1'b0;
              result_d = {bus.opa_i, {WIDTH{1'b0}}};
              state_d  = DONE;
            end else begin
              dz_d     = 1'b0;
              state_d  = CALC;
            end
          end
        end
        CALC: begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            cnt_d    = '0;
            result_d = {rem_fix, quo_fix};
            state_d  = DONE;
          end
        end
        DONE: begin
          // start_i here still belongs to the retiring instruction.
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      result_q  <= result_d;
    end
  end

  // Stall is qualified by rst so every output reads 0 while reset is held,
  // even if the pipeline keeps start_i asserted.
  assign bus.stall_div_o = rst & ~bus.flush_i &
                           (((state_q == IDLE) & bus.start_i) | (state_q == CALC));
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.valid_o     = (state_q == DONE) & ~bus.flush_i;
  assign bus.divzero_o   = (state_q == DONE) & ~bus.flush_i & dz_q;
  assign bus.result_o    = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;

  localparam int W = 32;

  logic clk;
  logic rst;

  div_sequencer_if #(.WIDTH(W)) bus ();

  div_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_ops    = 0;
  logic [63:0] last_res = '0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the operands. SV division truncates
  // toward zero and the remainder follows the dividend, which is exactly the
  // DIV/DIVU contract; the wide type keeps MIN / -1 well defined.
  function automatic void model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                output logic [63:0] res, output int lat, output bit dz);
    longint sa, sb, q, r, ma, mb;
    if (b == 32'd0) begin
      res = '0;
      lat = 1;
      dz  = 1'b1;
      return;
    end
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q   = sa / sb;
    r   = sa % sb;
    res = {r[31:0], q[31:0]};
    dz  = 1'b0;
    lat = W + 1;
    ma  = (sa < 0) ? -sa : sa;
    mb  = (sb < 0) ? -sb : sb;
`ifdef DIV_EARLY_EXIT_EN
    if (ma < mb) lat = 1;
`else
    if (ma < mb) lat = W + 1;
`endif
  endfunction

  // Runs one divide starting in the current cycle (called at posedge+1).
  // flush_at: cycle offset at which flush_i is pulsed, -1 for none.
  // hold: leave start_i high so the caller can issue back-to-back.
  task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input int flush_at, input bit hold);
    logic [63:0] exp_res;
    int          lat;
    bit          dz;
    bit          stop;
    model(sgn, a, b, exp_res, lat, dz);
    bus.start_i  = 1'b1;
    bus.signed_i = sgn;
    bus.opa_i    = a;
    bus.opb_i    = b;
    stop = 1'b0;
    for (int k = 0; k <= lat && !stop; k++) begin
      bus.flush_i = (k == flush_at);
      @(negedge clk);
      if (k == flush_at) begin
        check_val("stall_flush", 64'(bus.stall_div_o), 64'd0);
        check_val("valid_flush", 64'(bus.valid_o), 64'd0);
        if (k == lat) last_res = exp_res;
        stop = 1'b1;
      end else begin
        check_val("stall", 64'(bus.stall_div_o), 64'(k < lat));
        check_val("valid", 64'(bus.valid_o), 64'(k == lat));
        check_val("busy", 64'(bus.busy_o), 64'(k > 0));
        if (k == lat) begin
          check_val("result", bus.result_o, exp_res);
          check_val("divzero", 64'(bus.divzero_o), 64'(dz));
          last_res = exp_res;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.flush_i = 1'b0;
    n_ops++;
    $display("op %0d: %s a=%h b=%h flush_at=%0d lat=%0d exp=%h", n_ops,
             sgn ? "DIV " : "DIVU", a, b, flush_at, lat, exp_res);
    if (!hold) begin
      bus.start_i = 1'b0;
      @(negedge clk);
      check_val("idle_busy", 64'(bus.busy_o), 64'd0);
      check_val("idle_valid", 64'(bus.valid_o), 64'd0);
      check_val("idle_stall", 64'(bus.stall_div_o), 64'd0);
      check_val("result_held", bus.result_o, last_res);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_mid_op();
    bus.start_i  = 1'b1;
    bus.signed_i = 1'b0;
    bus.opa_i    = 32'd100;
    bus.opb_i    = 32'd7;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    check_val("rst_stall", 64'(bus.stall_div_o), 64'd0);
    check_val("rst_busy", 64'(bus.busy_o), 64'd0);
    check_val("rst_valid", 64'(bus.valid_o), 64'd0);
    check_val("rst_divzero", 64'(bus.divzero_o), 64'd0);
    check_val("rst_result", bus.result_o, 64'd0);
    last_res = '0;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_val("post_rst_busy", 64'(bus.busy_o), 64'd0);
    @(posedge clk);
    #1;
    $display("op reset: rst asserted mid-divide, outputs cleared");
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit          rs, rh;
    int          rf;

    rst          = 1'b0;
    bus.start_i  = 1'b0;
    bus.signed_i = 1'b0;
    bus.flush_i  = 1'b0;
    bus.opa_i    = '0;
    bus.opb_i    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_stall", 64'(bus.stall_div_o), 64'd0);
    check_val("reset_busy", 64'(bus.busy_o), 64'd0);
    check_val("reset_valid", 64'(bus.valid_o), 64'd0);
    check_val("reset_divzero", 64'(bus.divzero_o), 64'd0);
    check_val("reset_result", bus.result_o, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_div(1'b0, 32'd100, 32'd7, -1, 1'b0);
    run_div(1'b1, -32'sd7, 32'd2, -1, 1'b0);
    run_div(1'b1, 32'd7, -32'sd2, -1, 1'b0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
    run_div(1'b0, 32'd5, 32'd0, -1, 1'b0);
    run_div(1'b0, 32'd100, 32'd7, 10, 1'b0);
    run_div(1'b0, 32'd100, 32'd7, -1, 1'b0);
    run_div(1'b0, 32'd3, 32'd5, -1, 1'b0);
    run_div(1'b1, -32'sd3, 32'd5, -1, 1'b1);
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, -1, 1'b1);
    run_div(1'b1, 32'd9, 32'd0, -1, 1'b0);
    reset_mid_op();
    run_div(1'b0, 32'd100, 32'd7, -1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = ra ^ 32'($urandom_range(0, 3));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      rh = ($urandom_range(0, 3) == 0);
      rf = -1;
      if (!rh && $urandom_range(0, 5) == 0) rf = $urandom_range(0, 33);
      run_div(rs, ra, rb, rf, rh);
    end
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
